subbytes_iter: RTL and testbench

//  Iterative, parametrised AES SubBytes/InvSubBytes engine for area-constrained AES128 builds.

---
 rtl/aes_pkg.sv | 16 +
 rtl/inv_sbox.sv | 32 +++
 rtl/sbox.sv | 32 +++
 rtl/subbytes_iter.sv | 106 ++++++++++
 tb/tb_subbytes_iter.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and types for the iterative SubBytes engine.
package aes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_NBYTES  = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } sub_state_e;

    localparam logic SUB_ENC = 1'b0;
    localparam logic SUB_DEC = 1'b1;

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box as a pure combinational lookup table.
module inv_sbox (
    input  logic [7:0] index,
    output logic [7:0] o
);

    // Row r holds InvS(16r) .. InvS(16r+15), first entry in the most significant byte.
    localparam logic [127:0] ROWS [16] = '{
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    logic [127:0] row;

    assign row = ROWS[index[7:4]];
    assign o   = row[{~index[3:0], 3'b000} +: 8];

endmodule

// File: rtl/sbox.sv
// AES forward S-box as a pure combinational lookup table.
module sbox (
    input  logic [7:0] index,
    output logic [7:0] o
);

    // Row r holds S(16r) .. S(16r+15), first entry in the most significant byte.
    localparam logic [127:0] ROWS [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [127:0] row;

    assign row = ROWS[index[7:4]];
    assign o   = row[{~index[3:0], 3'b000} +: 8];

endmodule

// File: rtl/subbytes_iter.sv
// Iterative AES SubBytes/InvSubBytes: LANES bytes per beat, 16/LANES beats per state.
module subbytes_iter
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] istate,
    input  logic                   in_dec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] ostate,
    output logic                   busy
);

    localparam int unsigned NBEATS = AES_NBYTES / LANES;
    localparam int unsigned CNTW   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(NBEATS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    sub_state_e                  state_q;
    logic [CNTW-1:0]             cnt_q;
    logic                        mode_q;
    logic [AES_NBYTES-1:0][7:0]  data_q;

    logic [3:0]                  base;
    logic [LANES-1:0][7:0]       lane_in;
    logic [LANES-1:0][7:0]       lane_fwd;
    logic [LANES-1:0][7:0]       lane_inv;
    logic [LANES-1:0][7:0]       lane_out;
    logic                        accept;

    // First byte handled this beat; bytes advance from byte 0 upward.
    assign base = 4'(32'(cnt_q) * LANES);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_in[g] = data_q[base + 4'(g)];

        sbox u_fwd (
            .index(lane_in[g]),
            .o    (lane_fwd[g])
        );

        inv_sbox u_inv (
            .index(lane_in[g]),
            .o    (lane_inv[g])
        );

        assign lane_out[g] = (mode_q == SUB_DEC) ? lane_inv[g] : lane_fwd[g];
    end

    // DONE with out_ready frees the result register, so a new state can load in that same cycle.
    assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StBusy);
    assign ostate    = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mode_q  <= SUB_ENC;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        data_q  <= istate;
                        mode_q  <= in_dec;
                        cnt_q   <= '0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    for (int i = 0; i < LANES; i++) begin
                        data_q[base + 4'(i)] <= lane_out[i];
                    end
                    if (cnt_q == LAST_BEAT) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (accept) begin
                        data_q  <= istate;
                        mode_q  <= in_dec;
                        cnt_q   <= '0;
                        state_q <= StBusy;
                    end else if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_subbytes_iter.sv
// Self-checking bench for subbytes_iter with LANES = 1, 4 and 16 instances side by side.
module tb_subbytes_iter;

    localparam int NCFG    = 3;
    localparam int NVEC    = 6;
    localparam int NSTREAM = 1000;

    logic         clk;
    logic         rst_n;
    logic         in_valid  [NCFG];
    logic         in_ready  [NCFG];
    logic [127:0] istate    [NCFG];
    logic         in_dec    [NCFG];
    logic         out_valid [NCFG];
    logic         out_ready [NCFG];
    logic [127:0] ostate    [NCFG];
    logic         busy      [NCFG];

    int errors;
    int checks;

    logic [7:0] fwd_tbl [256];
    logic [7:0] inv_tbl [256];

    typedef struct {
        logic [127:0] data;
        logic         dec;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [NVEC];

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        subbytes_iter #(
            .LANES(g == 0 ? 1 : (g == 1 ? 4 : 16))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .istate   (istate[g]),
            .in_dec   (in_dec[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .ostate   (ostate[g]),
            .busy     (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic int lanes_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 4 : 16);
    endfunction

    // Reference S-box built from GF(2^8) inversion plus the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            fwd_tbl[x] = s;
            inv_tbl[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic dec);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = dec ? inv_tbl[d[8*i +: 8]] : fwd_tbl[d[8*i +: 8]];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int g = 0; g < NCFG; g++) begin
            in_valid[g]  = 1'b0;
            in_dec[g]    = 1'b0;
            out_ready[g] = 1'b0;
            istate[g]    = '0;
        end
    endtask

    task automatic reset_dut(input int k, input string tag);
        clear_inputs();
        rst_n = 1'b0;
        #1;
        check({tag, " rst out_valid"}, 128'(out_valid[k]), 128'(0));
        check({tag, " rst in_ready"}, 128'(in_ready[k]), 128'(1));
        check({tag, " rst busy"}, 128'(busy[k]), 128'(0));
        check({tag, " rst ostate"}, ostate[k], 128'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int k, output int lat);
        lat = 0;
        while (!out_valid[k] && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake(input int k);
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
    endtask

    task automatic do_txn(input int k, input logic [127:0] data, input logic dec,
                          input logic [127:0] exp, input string name);
        int lat;
        istate[k]   = data;
        in_dec[k]   = dec;
        in_valid[k] = 1'b1;
        #1;
        check({name, " in_ready"}, 128'(in_ready[k]), 128'(1));
        tick();
        in_valid[k] = 1'b0;
        wait_done(k, lat);
        check({name, " latency"}, 128'(lat), 128'(16 / lanes_of(k)));
        check({name, " ostate"}, ostate[k], exp);
        handshake(k);
        check({name, " released"}, 128'(out_valid[k]), 128'(0));
    endtask

    task automatic backpressure(input int k, input string tag);
        int lat;
        do_accept(k, vecs[0].data, 1'b0);
        wait_done(k, lat);
        for (int c = 0; c < 5; c++) begin
            in_valid[k] = 1'b1;
            istate[k]   = '0;
            in_dec[k]   = 1'b0;
            #1;
            check($sformatf("%s bp%0d out_valid", tag, c), 128'(out_valid[k]), 128'(1));
            check($sformatf("%s bp%0d ostate", tag, c), ostate[k], vecs[0].exp);
            check($sformatf("%s bp%0d in_ready", tag, c), 128'(in_ready[k]), 128'(0));
            tick();
        end
        out_ready[k] = 1'b1;
        #1;
        check({tag, " b2b in_ready"}, 128'(in_ready[k]), 128'(1));
        tick();
        out_ready[k] = 1'b0;
        in_valid[k]  = 1'b0;
        #1;
        check({tag, " b2b busy"}, 128'(busy[k]), 128'(1));
        check({tag, " b2b out_valid"}, 128'(out_valid[k]), 128'(0));
        wait_done(k, lat);
        check({tag, " b2b latency"}, 128'(lat), 128'(16 / lanes_of(k)));
        check({tag, " b2b ostate"}, ostate[k], {16{8'h63}});
        handshake(k);
    endtask

    task automatic do_accept(input int k, input logic [127:0] data, input logic dec);
        istate[k]   = data;
        in_dec[k]   = dec;
        in_valid[k] = 1'b1;
        tick();
        in_valid[k] = 1'b0;
    endtask

    task automatic noise(input int k, input string tag);
        int n;
        do_accept(k, vecs[0].data, 1'b0);
        n = 0;
        while (!out_valid[k] && n < 64) begin
            in_valid[k] = ~in_valid[k];
            in_dec[k]   = ~in_dec[k];
            istate[k]   = {16{8'h53}};
            #1;
            check($sformatf("%s noise%0d in_ready", tag, n), 128'(in_ready[k]), 128'(0));
            tick();
            n++;
        end
        in_valid[k] = 1'b0;
        in_dec[k]   = 1'b0;
        check({tag, " noise latency"}, 128'(n), 128'(16 / lanes_of(k)));
        check({tag, " noise ostate"}, ostate[k], vecs[0].exp);
        handshake(k);
        do_txn(k, {16{8'h53}}, 1'b0, {16{8'hed}}, {tag, " after-noise"});
    endtask

    task automatic mid_reset(input int k, input string tag);
        do_accept(k, vecs[0].data, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check({tag, " mid-rst out_valid"}, 128'(out_valid[k]), 128'(0));
        check({tag, " mid-rst ostate"}, ostate[k], 128'(0));
        check({tag, " mid-rst in_ready"}, 128'(in_ready[k]), 128'(1));
        check({tag, " mid-rst busy"}, 128'(busy[k]), 128'(0));
        tick();
        rst_n = 1'b1;
        tick();
        check({tag, " post-rst out_valid"}, 128'(out_valid[k]), 128'(0));
        do_txn(k, '0, 1'b0, {16{8'h63}}, {tag, " post-rst"});
    endtask

    task automatic stream(input int k, input string tag);
        logic [127:0] expq [$];
        logic [127:0] exp;
        logic         pend;
        int           sent;
        int           got;
        int           cyc;
        pend = 1'b0;
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < NSTREAM && cyc < 40 * NSTREAM) begin
            if (!pend && sent < NSTREAM) begin
                istate[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
                in_dec[k] = 1'($urandom_range(1, 0));
                pend      = 1'b1;
            end
            in_valid[k]  = pend;
            out_ready[k] = ($urandom_range(3, 0) != 0);
            #1;
            if (out_valid[k] && out_ready[k]) begin
                if (expq.size() == 0) begin
                    check($sformatf("%s stream extra result %0d", tag, got), ostate[k], 128'hx);
                end else begin
                    exp = expq.pop_front();
                    check($sformatf("%s stream %0d", tag, got), ostate[k], exp);
                end
                got++;
            end
            if (pend && in_ready[k]) begin
                expq.push_back(ref_sub(istate[k], in_dec[k]));
                sent++;
                pend = 1'b0;
            end
            tick();
            cyc++;
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b0;
        check({tag, " stream count"}, 128'(got), 128'(NSTREAM));
        check({tag, " stream leftover"}, 128'(expq.size()), 128'(0));
    endtask

    task automatic run_cfg(input int k);
        string tag;
        tag = $sformatf("L%0d", lanes_of(k));
        reset_dut(k, tag);
        for (int v = 0; v < NVEC; v++) begin
            do_txn(k, vecs[v].data, vecs[v].dec, vecs[v].exp, $sformatf("%s vec%0d", tag, v));
        end
        backpressure(k, tag);
        noise(k, tag);
        mid_reset(k, tag);
        stream(k, tag);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clear_inputs();
        rst_n = 1'b0;
        build_tables();

        // Expected values taken byte by byte from the FIPS-197 S-box tables.
        vecs[0] = '{128'hffeeddccbbaa99887766554433221100, 1'b0,
                    128'h1628c14beaaceec4f533fc1bc3938263};
        vecs[1] = '{128'h1628c14beaaceec4f533fc1bc3938263, 1'b1,
                    128'hffeeddccbbaa99887766554433221100};
        vecs[2] = '{{16{8'h00}}, 1'b0, {16{8'h63}}};
        vecs[3] = '{{16{8'h53}}, 1'b0, {16{8'hed}}};
        vecs[4] = '{{16{8'hed}}, 1'b1, {16{8'h53}}};
        vecs[5] = '{{16{8'h63}}, 1'b1, {16{8'h00}}};

        tick();
        for (int k = 0; k < NCFG; k++) begin
            run_cfg(k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
